// File: rtl/status_irq_pkg.sv
// status_irq_pkg: status word layout and IRQ FSM states shared by the status IRQ controller.
package status_irq_pkg;
    localparam int STATUS_W         = 14;
    localparam int ENSAMP_BIT       = 13;
    localparam int CFGCHNG_BIT      = 12;
    localparam int ANALOG_RESET_BIT = 11;
    localparam int FIFO_UDF_BIT     = 10;
    localparam int FIFO_OVF_BIT     = 9;
    localparam int ADC_OVF_BIT      = 8;
    localparam int SAT_MSB          = 7;
    localparam int SAT_LSB          = 0;
    typedef enum logic [1:0] {IDLE, PULSE, WAIT, HOLDOFF} irq_state_e;
endpackage

// File: rtl/status_irq_fsm.sv
// status_irq_fsm: IRQ pin sequencing (level/pulse, re-arm on new causes, post-clear holdoff).
module status_irq_fsm
    import status_irq_pkg::*;
#(
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 4
) (
    input  logic HF_CLK,
    input  logic RST_sync,
    input  logic cause,
    input  logic new_bits,
    input  logic irq_mode,
    input  logic status_clr_pulse,
    output logic IRQ
);
    localparam int CW = $clog2((PULSE_CYCLES > HOLDOFF_CYCLES ? PULSE_CYCLES : HOLDOFF_CYCLES) + 1);
    irq_state_e state, nxt;
    logic [CW-1:0] cnt, cnt_n;
    logic mode_q, irq_n;
    always_ff @(posedge HF_CLK or posedge RST_sync) begin
        if (RST_sync) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 1'b0;
            IRQ    <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_n;
            mode_q <= irq_mode;
            IRQ    <= irq_n;
        end
    end
    // IRQ is registered from the next state so the pin tracks the state with no extra lag
    always_comb begin
        nxt   = state;
        cnt_n = cnt;
        if (status_clr_pulse) begin
            nxt   = HOLDOFF;
            cnt_n = CW'(HOLDOFF_CYCLES - 1);
        end else if (irq_mode != mode_q) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (cause && irq_mode) begin
                    nxt   = PULSE;
                    cnt_n = CW'(PULSE_CYCLES - 1);
                end
                PULSE: if (cnt == '0) nxt = WAIT; else cnt_n = cnt - 1'b1;
                WAIT: if (new_bits) begin
                    nxt   = PULSE;
                    cnt_n = CW'(PULSE_CYCLES - 1);
                end else if (!cause) nxt = IDLE;
                HOLDOFF: if (cnt == '0) nxt = IDLE; else cnt_n = cnt - 1'b1;
                default: nxt = IDLE;
            endcase
        end
        irq_n = (nxt == PULSE) || (nxt == IDLE && !irq_mode && cause);
    end
endmodule

// File: rtl/status_irq_ctrl.sv
// status_irq_ctrl: MCU status snapshot, W1C clear generation, ENSAMP event and IRQ cause logic.
module status_irq_ctrl
    import status_irq_pkg::*;
#(
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 4,
    parameter bit CLR_GUARD      = 1'b1
) (
    input  logic                HF_CLK,
    input  logic                RST_sync,
    input  logic [STATUS_W-1:0] status,
    input  logic [STATUS_W-1:0] irq_en,
    input  logic                irq_mode,
    input  logic                status_rd_strobe,
    input  logic                status_wr_strobe,
    input  logic [STATUS_W-1:0] status_wr_data,
    output logic [STATUS_W-1:0] status_rdata,
    output logic                status_clr_pulse,
    output logic [STATUS_W-1:0] status_clr_mask,
    output logic                IRQ
);
    logic [CFGCHNG_BIT:0] m;
    logic                 ens_evt, ens_prev, clr;
    logic [STATUS_W-1:0]  cv_r, cv_prev;
    // guard uses the snapshot held before this cycle's read update
    assign m   = status_wr_data[CFGCHNG_BIT:0] & (CLR_GUARD ? status_rdata[CFGCHNG_BIT:0] : '1);
    assign clr = status_wr_strobe && (|m);
    always_ff @(posedge HF_CLK or posedge RST_sync) begin
        if (RST_sync) begin
            status_rdata     <= '0;
            status_clr_pulse <= 1'b0;
            status_clr_mask  <= '0;
            ens_evt          <= 1'b0;
            ens_prev         <= 1'b0;
            cv_r             <= '0;
            cv_prev          <= '0;
        end else begin
            if (status_rd_strobe) status_rdata <= status;
            status_clr_pulse <= clr;
            status_clr_mask  <= clr ? {1'b0, m} : '0;
            ens_prev         <= status[ENSAMP_BIT];
            ens_evt          <= (status[ENSAMP_BIT] != ens_prev) ||
                                (ens_evt && !(status_wr_strobe && status_wr_data[ENSAMP_BIT]));
            cv_r             <= {ens_evt & irq_en[ENSAMP_BIT], status[CFGCHNG_BIT:0] & irq_en[CFGCHNG_BIT:0]};
            cv_prev          <= cv_r;
        end
    end
    status_irq_fsm #(
        .PULSE_CYCLES  (PULSE_CYCLES),
        .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_fsm (
        .HF_CLK          (HF_CLK),
        .RST_sync        (RST_sync),
        .cause           (|cv_r),
        .new_bits        (|(cv_r & ~cv_prev)),
        .irq_mode        (irq_mode),
        .status_clr_pulse(status_clr_pulse),
        .IRQ             (IRQ)
    );
endmodule

// File: doc/status_irq_ctrl.md
# status_irq_ctrl

Register-side companion to the status monitor, directly downstream of it. Consumes the 14-bit sticky status word, serves MCU status reads through a snapshot register, and converts MCU write-1-to-clear accesses into the `status_clr_pulse`/`status_clr_mask` pair that the monitor consumes. Drives the chip `IRQ` pin from enabled status causes in level or fixed-width pulse mode, with a post-clear holdoff.

## Interface
- `STATUS_W`, 14: status word width. Bit map: 13 ENSAMP, 12 CFGCHNG, 11 ANALOG_RESET, 10 FIFO_UDF, 9 FIFO_OVF, 8 ADC_OVF, 7:0 SAT.
- `PULSE_CYCLES`, 16: IRQ high time in pulse mode, in HF_CLK cycles. Must be ≥ 1.
- `HOLDOFF_CYCLES`, 4: forced-low IRQ time after a clear. Must be ≥ 1.
- `CLR_GUARD`, 1: when 1, a clear only takes effect on bits that were set in the last snapshot.

Ports:
- `HF_CLK` in 1: the single clock.
- `RST_sync` in 1: reset, asynchronous, active-high.
- `status` in 14: status word from the monitor.
- `irq_en` in 14: per-bit interrupt enable.
- `irq_mode` in 1: 0 = level, 1 = pulse.
- `status_rd_strobe` in 1: one-cycle MCU status read.
- `status_wr_strobe` in 1: one-cycle MCU W1C write.
- `status_wr_data` in 14: W1C data.
- `status_rdata` out 14: snapshot returned to the MCU.
- `status_clr_pulse` out 1: one-cycle clear strobe to the monitor.
- `status_clr_mask` out 14: clear mask; bit 13 is always 0.
- `IRQ` out 1: interrupt pin.

## Operation
- **Reset.** `status_rdata`, `status_clr_pulse`, `status_clr_mask`, `IRQ`, `ens_evt` and the counters are all 0. FSM is in IDLE.
- **Snapshot.** On `status_rd_strobe`, `status_rdata <= status`. It holds otherwise.
- **W1C.**
  - On `status_wr_strobe`, compute `m = status_wr_data[12:0]`, ANDed with `status_rdata[12:0]` when `CLR_GUARD` = 1.
  - If `m` ≠ 0: `status_clr_pulse` = 1 and `status_clr_mask` = {1'b0, m} for exactly the next cycle; otherwise both stay 0.
  - `status_clr_mask` returns to 0 when the pulse drops.
  - `status_wr_data[13]` = 1 clears `ens_evt` (not forwarded to the monitor).
- **ENSAMP event.** `ens_evt` sets on any change of `status[13]` versus its registered previous value and is sticky until cleared by W1C bit 13. Set wins over clear in the same cycle.
- **Cause vector.** `cv = {ens_evt & irq_en[13], status[12:0] & irq_en[12:0]}`, registered as `cv_r`. `cause = |cv_r`. `new_bits = cv_r & ~cv_prev`, where `cv_prev` is `cv_r` delayed one cycle.
- **FSM (IDLE, PULSE, WAIT, HOLDOFF).**
  - IDLE: `IRQ` = `cause` in level mode, 0 in pulse mode. If `cause`: in pulse mode go to PULSE with `cnt` = PULSE_CYCLES−1; in level mode stay in IDLE.
  - PULSE: `IRQ` = 1. `cnt` decrements; at 0 go to WAIT.
  - WAIT: `IRQ` = 0. If `new_bits` ≠ 0, go to PULSE (reload `cnt`). Else if `!cause`, go to IDLE.
  - HOLDOFF: `IRQ` = 0 for `HOLDOFF_CYCLES`, then go to IDLE, which re-evaluates `cause`.
  - Any state goes to HOLDOFF in the cycle `status_clr_pulse` is asserted. This has priority over all other transitions and reloads the holdoff counter.
  - A change of `irq_mode` forces IDLE the next cycle (unless the HOLDOFF entry condition also holds, which wins).
- **Simultaneous read and write.** The snapshot captures the pre-clear `status`. The guard uses the snapshot value held before that cycle's update.
- **Write during an active `status_clr_pulse`.** It produces a second pulse in the following cycle and restarts HOLDOFF.

## Timing
- Snapshot: `status_rdata` is valid 1 cycle after `status_rd_strobe`.
- Clear: `status_clr_pulse` is high exactly 1 cycle, starting 1 cycle after `status_wr_strobe`. The monitor flag therefore drops 2 cycles after the strobe.
- IRQ assert: `status` bit to `IRQ` is 2 cycles (`cv_r` register, then FSM/output register); `IRQ` is registered.
- Pulse mode: `IRQ` width is exactly `PULSE_CYCLES`.
- Holdoff: low for exactly `HOLDOFF_CYCLES`, starting the cycle after `status_clr_pulse`.
- Re-interrupt: if a cause is still pending after HOLDOFF, `IRQ` re-asserts 1 cycle after leaving HOLDOFF.

## Structure
- **Package `status_irq_pkg`:** `STATUS_W`, bit-index constants (`ENSAMP_BIT` = 13 … `SAT_LSB` = 0), and the FSM state enum.
- **Sub-module `status_irq_fsm`:** FSM plus pulse/holdoff counters. Inputs: `cause`, `new_bits` ≠ 0, `irq_mode`, `status_clr_pulse`. Output: `IRQ`.
- **Top level:** snapshot, W1C logic and `ens_evt`.

## Test plan
- Reset mid-PULSE (`RST_sync` high for 1 cycle) → `IRQ`, `status_clr_pulse`, `status_clr_mask` and `status_rdata` all 0 immediately; FSM in IDLE.
- Level mode, `irq_en` = 0x0200, `status[9]` rises → `IRQ` = 1 two cycles later. Read (`status_rdata` = 0x0200), then write 0x0200 → one-cycle pulse with mask 0x0200 and `IRQ` low for 4 cycles. If `status[9]` is still 1 afterwards, `IRQ` returns.
- Pulse mode, `status[3]` set (`irq_en[3]` = 1) → `IRQ` high for exactly 16 cycles. A later `status[5]` rise while in WAIT (`irq_en[5]` = 1) → a second 16-cycle pulse.
- `CLR_GUARD` = 1, snapshot = 0x0001, write 0x0003 → mask 0x0001. Write 0x2000 → no pulse, `ens_evt` cleared.
- ENSAMP toggle with `irq_en[13]` = 1 → `ens_evt` = 1 and `IRQ` asserts. Write 0x2000 → `ens_evt` = 0 and `status_clr_mask[13]` never 1.
- Same-cycle read and write with `status` = 0x0300 and prior snapshot 0x0100 → `status_rdata` = 0x0300, mask = 0x0100.
